// File: rtl/can_tx_frame_sequencer_if.sv
// CAN TX frame sequencer port bundle: mailbox request, bit-timing/stuffer strobes, bus bit and status.
// Latency: none (wires only).
// Backpressure: stuff_hold from the stuffer freezes the sequencer; no other flow control.
//
// Port summary:
//   enable, sample_point, Tx_request, tx_id, tx_dlc, tx_data, rx_bit, stuff_hold -> sequencer
//   tx_bit, field, bit_counter, stuff_enable, busy, tx_done, arb_lost, ack_error <- sequencer
interface can_tx_frame_sequencer_if;
  logic        enable;
  logic        sample_point;
  logic        Tx_request;
  logic [10:0] tx_id;
  logic [3:0]  tx_dlc;
  logic [63:0] tx_data;
  logic        rx_bit;
  logic        stuff_hold;
  logic        tx_bit;
  logic [3:0]  field;
  logic [5:0]  bit_counter;
  logic        stuff_enable;
  logic        busy;
  logic        tx_done;
  logic        arb_lost;
  logic        ack_error;

  // Master: mailbox / bit-timing side that drives the sequencer.
  modport master (
    output enable, sample_point, Tx_request, tx_id, tx_dlc, tx_data, rx_bit, stuff_hold,
    input  tx_bit, field, bit_counter, stuff_enable, busy, tx_done, arb_lost, ack_error
  );

  // Slave: the sequencer itself.
  modport slave (
    input  enable, sample_point, Tx_request, tx_id, tx_dlc, tx_data, rx_bit, stuff_hold,
    output tx_bit, field, bit_counter, stuff_enable, busy, tx_done, arb_lost, ack_error
  );
endinterface

// File: rtl/can_tx_frame_sequencer.sv
// CAN 2.0A standard data frame sequencer (SOF..IFS) with internal CRC-15, arbitration and ACK checks.
// Latency: frame starts the clock after a request in IDLE; tx_bit/field/bit_counter follow each consumed bit in the same cycle.
// Backpressure: a bit is consumed only on sample_point with stuff_hold low; stuff_hold freezes all state.
//
// Ports: clock, reset_n (async active-low) plus the slave side of can_tx_frame_sequencer_if.
//   Status pulses tx_done / arb_lost / ack_error are registered and appear together with the return to IDLE.
module can_tx_frame_sequencer #(
  parameter logic [14:0] CRC_POLY = 15'h4599,
  parameter int          EOF_BITS = 7,
  parameter int          IFS_BITS = 3
) (
  input logic                     clock,
  input logic                     reset_n,
  can_tx_frame_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_SOF      = 4'd1,
    S_ARB      = 4'd2,
    S_CTRL     = 4'd3,
    S_DATA     = 4'd4,
    S_CRC      = 4'd5,
    S_CRC_DEL  = 4'd6,
    S_ACK_SLOT = 4'd7,
    S_ACK_DEL  = 4'd8,
    S_EOF      = 4'd9,
    S_IFS      = 4'd10
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [14:0] crc_q, crc_d;
  logic [10:0] id_q;
  logic [3:0]  dlc_q;
  logic [63:0] data_q;
  logic        tx_done_q, tx_done_d;
  logic        arb_lost_q, arb_lost_d;
  logic        ack_error_q, ack_error_d;
  logic        load;

  logic        consume;
  logic        tx_bit_c;
  logic [6:0]  data_len;
  logic [6:0]  field_len;
  logic        last_bit;
  logic [3:0]  arb_idx;
  logic [1:0]  dlc_idx;
  logic [5:0]  data_idx;
  logic [3:0]  crc_idx;

  assign consume  = bus.sample_point & ~bus.stuff_hold;

  // Any DLC with bit 3 set (8..15) carries the full 8 bytes.
  assign data_len = dlc_q[3] ? 7'd64 : {1'b0, dlc_q[2:0], 3'b000};

  // MSB-first bit selectors for each field.
  assign arb_idx  = 4'd10 - cnt_q[3:0];
  assign dlc_idx  = 2'd1 - cnt_q[1:0];   // cnt 2..5 -> dlc bit 3..0
  assign data_idx = 6'd63 - cnt_q;
  assign crc_idx  = 4'd14 - cnt_q[3:0];  // CRC register is frozen during S_CRC

  always_comb begin
    tx_bit_c = 1'b1;
    case (state_q)
      S_SOF:   tx_bit_c = 1'b0;
      S_ARB:   tx_bit_c = (cnt_q < 6'd11) ? id_q[arb_idx] : 1'b0;   // last ARB bit is RTR
      S_CTRL:  tx_bit_c = (cnt_q < 6'd2) ? 1'b0 : dlc_q[dlc_idx];   // IDE, r0, then DLC
      S_DATA:  tx_bit_c = data_q[data_idx];
      S_CRC:   tx_bit_c = crc_q[crc_idx];
      default: tx_bit_c = 1'b1;
    endcase
  end

  always_comb begin
    field_len = 7'd1;
    case (state_q)
      S_ARB:   field_len = 7'd12;
      S_CTRL:  field_len = 7'd6;
      S_DATA:  field_len = data_len;
      S_CRC:   field_len = 7'd15;
      S_EOF:   field_len = 7'(EOF_BITS);
      S_IFS:   field_len = 7'(IFS_BITS);
      default: field_len = 7'd1;
    endcase
  end

  assign last_bit = ({1'b0, cnt_q} == (field_len - 7'd1));

  // Next-state / pulse logic. Priority: enable low, then start, then arbitration/ACK aborts, then advance.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    load        = 1'b0;
    tx_done_d   = 1'b0;
    arb_lost_d  = 1'b0;
    ack_error_d = 1'b0;

    if (!bus.enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      crc_d   = '0;
    end else if (state_q == S_IDLE) begin
      if (bus.Tx_request) begin
        load    = 1'b1;
        crc_d   = '0;
        cnt_d   = '0;
        state_d = S_SOF;
      end
    end else if (consume) begin
      if (state_q inside {S_SOF, S_ARB, S_CTRL, S_DATA}) begin
        crc_d = {crc_q[13:0], 1'b0} ^ ((tx_bit_c ^ crc_q[14]) ? CRC_POLY : 15'h0);
      end

      if (state_q == S_ARB && tx_bit_c && !bus.rx_bit) begin
        arb_lost_d = 1'b1;
        state_d    = S_IDLE;
        cnt_d      = '0;
      end else if (state_q == S_ACK_SLOT && bus.rx_bit) begin
        ack_error_d = 1'b1;
        state_d     = S_IDLE;
        cnt_d       = '0;
      end else if (last_bit) begin
        cnt_d = '0;
        case (state_q)
          S_SOF:      state_d = S_ARB;
          S_ARB:      state_d = S_CTRL;
          S_CTRL:     state_d = (dlc_q == 4'd0) ? S_CRC : S_DATA;
          S_DATA:     state_d = S_CRC;
          S_CRC:      state_d = S_CRC_DEL;
          S_CRC_DEL:  state_d = S_ACK_SLOT;
          S_ACK_SLOT: state_d = S_ACK_DEL;
          S_ACK_DEL:  state_d = S_EOF;
          S_EOF:      state_d = S_IFS;
          S_IFS: begin
            state_d   = S_IDLE;
            tx_done_d = 1'b1;
          end
          default:    state_d = S_IDLE;
        endcase
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      crc_q       <= '0;
      id_q        <= '0;
      dlc_q       <= '0;
      data_q      <= '0;
      tx_done_q   <= 1'b0;
      arb_lost_q  <= 1'b0;
      ack_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      tx_done_q   <= tx_done_d;
      arb_lost_q  <= arb_lost_d;
      ack_error_q <= ack_error_d;
      if (load) begin
        id_q   <= bus.tx_id;
        dlc_q  <= bus.tx_dlc;
        data_q <= bus.tx_data;
      end
    end
  end

  assign bus.tx_bit       = tx_bit_c;
  assign bus.field        = state_q;
  assign bus.bit_counter  = cnt_q;
  assign bus.stuff_enable = (state_q >= S_SOF) && (state_q <= S_CRC);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.tx_done      = tx_done_q;
  assign bus.arb_lost     = arb_lost_q;
  assign bus.ack_error    = ack_error_q;

endmodule

// File: doc/can_tx_frame_sequencer.md
Name: can_tx_frame_sequencer

Overview:
Sequences one complete CAN 2.0A standard data frame for transmission, from SOF through interframe space, one bit per sample_point. It latches ID, DLC and payload on request, drives the serialised bit, and computes CRC-15 internally. It performs arbitration-loss and ACK-slot checks against the received bus bit. It sits between the TX mailbox and the bit stuffer/bit-timing logic, and owns field sequencing for the whole frame.

Parameters:
CRC_POLY, 15'h4599, CAN CRC-15 generator polynomial
EOF_BITS, 7, end-of-frame recessive bit count
IFS_BITS, 3, intermission recessive bit count

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  controller enable; low aborts to IDLE
sample_point  in  1  one-clock pulse marking the bit boundary
Tx_request  in  1  frame transmit request (level)
tx_id  in  11  identifier, sent MSB first
tx_dlc  in  4  data length code
tx_data  in  64  payload; byte 0 = tx_data[63:56], sent MSB first
rx_bit  in  1  bus bit sampled at sample_point
stuff_hold  in  1  stuffer is inserting a stuff bit; do not advance
tx_bit  out  1  bit to drive (1 = recessive)
field  out  4  current state encoding
bit_counter  out  6  bit index within current field
stuff_enable  out  1  high in SOF..CRC (excludes CRC delimiter)
busy  out  1  state != IDLE
tx_done  out  1  one-clock pulse, frame completed
arb_lost  out  1  one-clock pulse, arbitration lost
ack_error  out  1  one-clock pulse, no dominant ACK

Behaviour:
- Reset (async): state IDLE, tx_bit=1, bit_counter=0, CRC=0, all pulses/flags 0, latched registers 0.
- States and field encoding:
  - 0 IDLE
  - 1 SOF (1 bit)
  - 2 ARB (ID 11 + RTR 1 = 12 bits)
  - 3 CTRL (IDE, r0, DLC[3:0] = 6 bits)
  - 4 DATA (8*min(dlc,8) bits)
  - 5 CRC (15 bits)
  - 6 CRC_DEL
  - 7 ACK_SLOT
  - 8 ACK_DEL
  - 9 EOF (EOF_BITS bits)
  - 10 IFS (IFS_BITS bits)
- Bit values:
  - SOF, RTR, IDE and r0 are 0.
  - CRC_DEL, ACK_SLOT, ACK_DEL, EOF and IFS are 1.
  - IDLE drives 1.
- Start:
  - In IDLE with enable=1 and Tx_request=1 on a clock edge: latch tx_id, tx_dlc and tx_data; clear CRC; enter SOF.
  - tx_bit=0 from the next cycle.
  - Starting does not require sample_point.
- Advance:
  - A bit is consumed only on a clock where sample_point=1 and stuff_hold=0.
  - On consumption: bit_counter increments. At the last bit of the field, move to the next state and set bit_counter=0.
  - tx_bit updates in the same cycle as the state/counter.
  - With stuff_hold=1, tx_bit, state, counter and CRC all hold.
- CRC:
  - On each consumed bit from SOF through DATA: crc_nxt = tx_bit ^ crc[14]; crc = {crc[13:0],1'b0} ^ (crc_nxt ? CRC_POLY : 0).
  - The CRC state sends crc[14] first.
- DLC:
  - DLC field transmits tx_dlc as latched.
  - Data length is min(dlc,8) bytes, so DLC 9..15 sends 8 bytes.
  - dlc=0 goes CTRL→CRC and skips DATA.
- Arbitration:
  - In ARB, on a consumed bit with tx_bit=1 and rx_bit=0: arb_lost pulse, state IDLE, tx_bit=1 next cycle, no tx_done.
- ACK:
  - In ACK_SLOT, on the consumed bit, rx_bit=1 raises ack_error pulse and aborts to IDLE.
  - rx_bit=0 continues to ACK_DEL.
- Completion:
  - Consuming the last IFS bit raises the tx_done pulse and enters IDLE.
  - If Tx_request is still high, a new frame starts on the following clock.
- Tx_request is ignored outside IDLE; dropping it mid-frame does not abort.
- enable=0 in any state: synchronous return to IDLE, tx_bit=1, bit_counter=0, CRC cleared, no pulses. Takes priority over all events.
- Simultaneous events: enable=0 overrides everything; arb_lost/ack_error override normal advance; pulses are mutually exclusive.
- Total frame length, excluding stuff bits: 47 + 8*min(dlc,8) bits.

Test Plan:
- dlc=0, id=11'h123, rx_bit mirrors tx_bit except ACK_SLOT=0 -> 47 consumed bits, DATA skipped, CRC matches bench model, tx_done once, busy falls with it.
- dlc=8, id=11'h7FF, data=64'hDEADBEEFCAFEBABE, ACK given -> 111 bits; DATA shows 64 bits MSB first; field sequence 1..10.
- id=11'h400; force rx_bit=0 on ARB bit 1 (tx=1) -> arb_lost pulse at that sample_point, IDLE next cycle, tx_bit=1, no tx_done.
- dlc=2, rx_bit=1 in ACK_SLOT -> ack_error pulse, IDLE; also dlc=4'hF -> 64 data bits, DLC field sends 1111.
- Assert stuff_hold for 3 sample_points mid-DATA -> tx_bit/bit_counter/CRC frozen; final CRC unchanged vs no-hold run.
- enable=0 at ARB bit 5, then re-enable with Tx_request=1 -> clean IDLE, then fresh frame restarts at SOF; async reset mid-DATA -> all outputs at reset values immediately.
